rf_wb_sched: RTL and testbench

Write-back scheduler and scoreboard for the integer register file (`sys_regs`). It shares the single register-file write port between two write-back requesters: req0 is the ALU and req1 is the load unit. It tracks which destination registers have a write outstanding and raises a hazard flag toward decode. It drives `sys_regs` `write_en` / `rd_addr` / `write_data` directly.

---
 rtl/rf_ctrl_pkg.sv | 15 +
 rtl/rr_arb2.sv | 44 ++++
 rtl/rf_wb_sched.sv | 105 ++++++++++
 tb/tb_rf_wb_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control definitions: widths, register count and
// write-back requester identifiers used by sys_regs, decode and rf_wb_sched.
package rf_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  // Write-back requester IDs; also the round-robin arbiter state encoding.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The requester that did not win the most
// recent accepted transfer wins a tie; reset favours requester 0.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  import rf_ctrl_pkg::*;

  wb_id_e last_grant;
  wb_id_e last_grant_nxt;

  // State register: remembers the requester of the last accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= WB_LSU;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  // Next state: follow the grant whenever a transfer is accepted.
  always_comb begin
    last_grant_nxt = last_grant;
    if (grant[0]) begin
      last_grant_nxt = WB_ALU;
    end else if (grant[1]) begin
      last_grant_nxt = WB_LSU;
    end
  end

  // Output: single valid wins outright, a tie goes to the non-last requester.
  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == WB_LSU) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler and scoreboard for the integer register file.
// Arbitrates ALU and load write-backs onto the single sys_regs write port,
// registers the write, and tracks outstanding destination registers.
module rf_wb_sched #(
  parameter int unsigned XLEN   = rf_ctrl_pkg::XLEN,
  parameter int unsigned REG_AW = rf_ctrl_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [REG_AW-1:0]    alloc_rd,
  input  logic [REG_AW-1:0]    chk_rs1,
  input  logic [REG_AW-1:0]    chk_rs2,
  input  logic [REG_AW-1:0]    chk_rd,
  output logic                 hazard,
  input  logic                 req0_valid,
  input  logic [REG_AW-1:0]    req0_rd,
  input  logic [XLEN-1:0]      req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [REG_AW-1:0]    req1_rd,
  input  logic [XLEN-1:0]      req1_data,
  output logic                 req1_ready,
  output logic                 rf_write_en,
  output logic [REG_AW-1:0]    rf_rd_addr,
  output logic [XLEN-1:0]      rf_write_data,
  output logic [2**REG_AW-1:0] busy_vec
);
  import rf_ctrl_pkg::*;

  localparam int unsigned NREGS = 2 ** REG_AW;

  logic [1:0]        grant;
  logic              accept;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic [NREGS-1:0]  busy_nxt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  // Mux the granted request onto the write path.
  always_comb begin
    sel_rd   = req0_rd;
    sel_data = req0_data;
    if (grant[1]) begin
      sel_rd   = req1_rd;
      sel_data = req1_data;
    end
  end

  // Registered register-file write port; x0 writes are consumed silently
  // and leave the address/data registers untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_en   <= 1'b0;
      rf_rd_addr    <= '0;
      rf_write_data <= '0;
    end else begin
      rf_write_en <= accept && (sel_rd != '0);
      if (accept && (sel_rd != '0)) begin
        rf_rd_addr    <= sel_rd;
        rf_write_data <= sel_data;
      end
    end
  end

  // Scoreboard next state: clear on the register-file write edge, set on
  // allocation (set wins on collision), x0 never busy.
  always_comb begin
    busy_nxt = busy_vec;
    if (rf_write_en) begin
      busy_nxt[rf_rd_addr] = 1'b0;
    end
    if (alloc_valid) begin
      busy_nxt[alloc_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_nxt;
    end
  end

  // Decode stall: any referenced non-zero register with a write outstanding.
  always_comb begin
    hazard = (busy_vec[chk_rs1] && (chk_rs1 != '0)) ||
             (busy_vec[chk_rs2] && (chk_rs2 != '0)) ||
             (busy_vec[chk_rd]  && (chk_rd  != '0));
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed testbench for rf_wb_sched with hand-computed expectations.
module tb_rf_wb_sched;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_write_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_write_data;
  logic [31:0] busy_vec;

  int checks;
  int errors;

  rf_wb_sched #(.XLEN(32), .REG_AW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_rd      (alloc_rd),
    .chk_rs1       (chk_rs1),
    .chk_rs2       (chk_rs2),
    .chk_rd        (chk_rd),
    .hazard        (hazard),
    .req0_valid    (req0_valid),
    .req0_rd       (req0_rd),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_rd       (req1_rd),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .rf_write_en   (rf_write_en),
    .rf_rd_addr    (rf_rd_addr),
    .rf_write_data (rf_write_data),
    .busy_vec      (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [4:0]  r0_rd [2];
  logic [4:0]  r1_rd [2];
  int unsigned exp_g [4];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset during an accepted req0 transfer drops it.
    rst = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h1234_5678;
    settle();
    check("rst_ready0", req0_ready, 1);
    step();
    rst = 1'b0; req0_valid = 1'b0;
    settle();
    check("rst_wen", rf_write_en, 0);
    check("rst_busy", busy_vec, 0);
    check("rst_addr", rf_rd_addr, 0);
    check("rst_data", rf_write_data, 0);

    // Alloc x5, hazard on each check port.
    alloc_valid = 1'b1; alloc_rd = 5'd5;
    step();
    alloc_valid = 1'b0;
    settle();
    check("alloc5_busy", busy_vec, 32'h0000_0020);
    chk_rs1 = 5'd5; settle();
    check("haz_rs1", hazard, 1);
    chk_rs1 = 5'd0; chk_rs2 = 5'd5; settle();
    check("haz_rs2", hazard, 1);
    chk_rs2 = 5'd0; chk_rd = 5'd5; settle();
    check("haz_rd", hazard, 1);
    chk_rd = 5'd6; settle();
    check("haz_none", hazard, 0);
    chk_rd = 5'd0; chk_rs1 = 5'd5;

    // Write-back of x5 releases the hazard on the write edge.
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
    settle();
    check("wb5_ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    settle();
    check("wb5_wen", rf_write_en, 1);
    check("wb5_addr", rf_rd_addr, 5);
    check("wb5_data", rf_write_data, 32'hDEAD_BEEF);
    check("wb5_haz_pre", hazard, 1);
    step();
    check("wb5_busy_clr", busy_vec, 0);
    check("wb5_haz_post", hazard, 0);
    check("wb5_wen_off", rf_write_en, 0);
    check("wb5_addr_hold", rf_rd_addr, 5);
    check("wb5_data_hold", rf_write_data, 32'hDEAD_BEEF);
    chk_rs1 = 5'd0;

    // req1 write to x0: accepted, no write strobe.
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h5555_AAAA;
    settle();
    check("x0_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    settle();
    check("x0_wen", rf_write_en, 0);
    check("x0_data_hold", rf_write_data, 32'hDEAD_BEEF);

    // Contention: both valid for 4 cycles, last winner was req1.
    r0_rd = '{5'd1, 5'd3};
    r1_rd = '{5'd2, 5'd4};
    exp_g = '{0, 1, 0, 1};
    begin
      int unsigned r0i;
      int unsigned r1i;
      r0i = 0; r1i = 0;
      for (int unsigned k = 0; k < 4; k++) begin
        req0_valid = 1'b1; req0_rd = r0_rd[r0i]; req0_data = 32'h1000_0000 + 32'(r0_rd[r0i]);
        req1_valid = 1'b1; req1_rd = r1_rd[r1i]; req1_data = 32'h2000_0000 + 32'(r1_rd[r1i]);
        settle();
        check($sformatf("cont_ready0_%0d", k), req0_ready, (exp_g[k] == 0) ? 1 : 0);
        check($sformatf("cont_ready1_%0d", k), req1_ready, (exp_g[k] == 1) ? 1 : 0);
        step();
        if (exp_g[k] == 0) r0i++; else r1i++;
        check($sformatf("cont_wen_%0d", k), rf_write_en, 1);
        check($sformatf("cont_addr_%0d", k), rf_rd_addr, k + 1);
        check($sformatf("cont_data_%0d", k), rf_write_data,
              (exp_g[k] == 0) ? 32'h1000_0000 + k + 1 : 32'h2000_0000 + k + 1);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    check("cont_wen_end", rf_write_en, 0);

    // Alloc x0 leaves busy_vec unchanged.
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    step();
    alloc_rd = 5'd0;
    step();
    alloc_valid = 1'b0;
    settle();
    check("alloc_x0", busy_vec, 32'h0000_0200);

    // Set/clear collision on x7: set wins.
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    step();
    alloc_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h0000_0777;
    step();
    req0_valid = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    settle();
    check("coll_wen", rf_write_en, 1);
    check("coll_addr", rf_rd_addr, 7);
    step();
    alloc_valid = 1'b0;
    settle();
    check("coll_busy", busy_vec, 32'h0000_0280);
    step();
    check("coll_busy_hold", busy_vec, 32'h0000_0280);

    // Stall hold: make req1 the last winner, then req0 wins the tie and req1 waits.
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = '0;
    step();
    req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 32'hCAFE_0011;
    req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'hBEEF_0010;
    settle();
    check("stall_ready0", req0_ready, 1);
    check("stall_ready1", req1_ready, 0);
    step();
    req0_rd = 5'd12; req0_data = 32'hBEEF_0012;
    settle();
    check("stall_w10_addr", rf_rd_addr, 10);
    check("stall_w10_data", rf_write_data, 32'hBEEF_0010);
    check("stall_ready1_b", req1_ready, 1);
    check("stall_ready0_b", req0_ready, 0);
    step();
    req1_valid = 1'b0;
    settle();
    check("stall_w11_wen", rf_write_en, 1);
    check("stall_w11_addr", rf_rd_addr, 11);
    check("stall_w11_data", rf_write_data, 32'hCAFE_0011);
    check("stall_ready0_c", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    settle();
    check("stall_w12_addr", rf_rd_addr, 12);
    check("stall_w12_data", rf_write_data, 32'hBEEF_0012);
    step();
    check("final_wen", rf_write_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
